// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
// Holds the FSM state encoding and the default WIDTH / NREQ / MUL_LAT values.
package mult_share_arbiter_pkg;

   localparam int DEF_WIDTH   = 6;
   localparam int DEF_NREQ    = 4;
   localparam int DEF_MUL_LAT = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_BUSY = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side bundle of the multiplier-sharing arbiter.
// Ports:
//   req    - per-requester request level
//   a_in   - packed operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in   - packed operand B, same packing
//   gnt    - one-hot grant, held while an operation is in flight
//   done   - one-hot, one-cycle result-valid pulse
//   result - captured product, held until the next completion
//   busy   - high while an operation is in flight
// Modports: master = requesting side, slave = arbiter.
interface mult_share_arbiter_if
   import mult_share_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic [2*WIDTH-1:0]    result;
   logic                  busy;

   modport master (output req, a_in, b_in, input gnt, done, result, busy);
   modport slave  (input req, a_in, b_in, output gnt, done, result, busy);

endinterface

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req  - request vector
//   ptr  - highest-priority index for this pick
//   gnt  - one-hot winner
//   idx  - winner index
//   any  - at least one request is pending
// Scans from ptr upward, wrapping NREQ-1 -> 0, and takes the first set bit.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any    = 1'b1;
            idx    = IW'(j);
            gnt[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one sequential multiplier among NREQ requesters.
// Ports:
//   clk         - system clock, posedge
//   rst         - synchronous active-low reset
//   bus         - requester bundle (req, a_in, b_in, gnt, done, result, busy)
//   mul_rst     - active-high multiplier reset, ~rst
//   mul_load    - one-cycle multiplier load strobe
//   mul_a/mul_b - multiplier operands, stable from LOAD through DONE
//   mul_product - multiplier product, sampled on the last BUSY cycle
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for any req; picks winner and latches its operands
// LOAD    | mul_load high for this single cycle
// BUSY    | counting MUL_LAT cycles of multiplier latency
// DONE    | done pulse for the winner, result valid, ptr advanced
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NREQ    = DEF_NREQ,
   parameter int MUL_LAT = DEF_MUL_LAT
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_share_arbiter_if.slave  bus,
   output logic                 mul_rst,
   output logic                 mul_load,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   input  logic [2*WIDTH-1:0]   mul_product
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MUL_LAT + 1);

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win;
   logic [CW-1:0]   cnt;

   logic [NREQ-1:0] pick_gnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;

   assign mul_rst = ~rst;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req (bus.req),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         win        <= '0;
         cnt        <= '0;
         bus.gnt    <= '0;
         bus.done   <= '0;
         bus.result <= '0;
         bus.busy   <= 1'b0;
         mul_load   <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
      end else begin
         bus.done <= '0;
         mul_load <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  win      <= pick_idx;
                  bus.gnt  <= pick_gnt;
                  bus.busy <= 1'b1;
                  // operands copied now so the requester may change them freely
                  mul_a    <= bus.a_in[int'(pick_idx)*WIDTH +: WIDTH];
                  mul_b    <= bus.b_in[int'(pick_idx)*WIDTH +: WIDTH];
                  mul_load <= 1'b1;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               cnt   <= '0;
               state <= ST_BUSY;
            end
            ST_BUSY: begin
               cnt <= cnt + 1'b1;
               // last BUSY cycle: product is valid now, capture it for DONE
               if (cnt == CW'(MUL_LAT - 1)) begin
                  bus.result <= mul_product;
                  bus.done   <= bus.gnt;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               bus.gnt  <= '0;
               bus.busy <= 1'b0;
               ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier of the same latency.
module tb_mult_share_arbiter;
   import mult_share_arbiter_pkg::*;

   localparam int W = 6;
   localparam int N = 4;
   localparam int L = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             mul_rst;
   logic             mul_load;
   logic [W-1:0]     mul_a;
   logic [W-1:0]     mul_b;
   logic [2*W-1:0]   mul_product;

   mult_share_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

   mult_share_arbiter #(.WIDTH(W), .NREQ(N), .MUL_LAT(L)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .mul_rst     (mul_rst),
      .mul_load    (mul_load),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product)
   );

   always #5 clk = ~clk;

   // multiplier model: product valid L cycles after the load cycle, zero before that
   logic [2*W-1:0] m_val;
   int             m_lat;
   logic           m_arm;
   always @(posedge clk) begin
      if (mul_rst) begin
         m_val <= '0;
         m_lat <= 0;
         m_arm <= 1'b0;
      end else if (mul_load) begin
         m_val <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
         m_lat <= L - 1;
         m_arm <= 1'b1;
      end else if (m_lat != 0) begin
         m_lat <= m_lat - 1;
      end
   end
   assign mul_product = (m_arm && m_lat == 0) ? m_val : '0;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic set_op(input int id, input int a, input int b);
      bus.a_in[id*W +: W] = W'(a);
      bus.b_in[id*W +: W] = W'(b);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // returns at the negedge of the first cycle with done!=0; d=0 on timeout
   task automatic wait_done(output logic [N-1:0] d, output logic [N-1:0] g,
                            output logic [2*W-1:0] r, output int cyc, output int loads);
      d = '0; g = '0; r = '0; cyc = 0; loads = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (mul_load) loads++;
         if (bus.done != '0) begin
            d   = bus.done;
            g   = bus.gnt;
            r   = bus.result;
            cyc = n;
            break;
         end
      end
   endtask

   logic [N-1:0]   d, g;
   logic [2*W-1:0] r;
   int             cyc, loads, cnt_done;
   int             t2_id [5] = '{0, 1, 2, 3, 0};
   int             t2_p  [4] = '{35, 120, 1320, 3906};

   initial begin
      rst      = 1'b0;
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;
      tick(3);
      chk("rst_gnt",    32'(bus.gnt),    0);
      chk("rst_done",   32'(bus.done),   0);
      chk("rst_result", 32'(bus.result), 0);
      chk("rst_busy",   32'(bus.busy),   0);
      chk("rst_load",   32'(mul_load),   0);
      chk("rst_mul_a",  32'(mul_a),      0);
      chk("rst_mul_b",  32'(mul_b),      0);
      chk("rst_mulrst", 32'(mul_rst),    1);
      rst = 1'b1;
      tick(2);
      chk("idle_mulrst", 32'(mul_rst), 0);

      // 1: single request, latency and full-scale product
      set_op(0, 63, 63);
      bus.req = 4'b0001;
      wait_done(d, g, r, cyc, loads);
      bus.req = '0;
      chk("t1_done",   32'(d),   32'b0001);
      chk("t1_result", 32'(r),   32'b1111_1000_0001);
      chk("t1_cycle",  32'(cyc), 8);
      chk("t1_loads",  32'(loads), 1);
      chk("t1_gnt",    32'(g),   32'b0001);
      tick(1);
      chk("t1_done_pulse", 32'(bus.done), 0);
      chk("t1_busy_off",   32'(bus.busy), 0);
      chk("t1_result_hold", 32'(bus.result), 3969);

      // 2: all requesting from ptr=0, expect 0,1,2,3,0
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      set_op(0, 5, 7);
      set_op(1, 10, 12);
      set_op(2, 33, 40);
      set_op(3, 63, 62);
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_done(d, g, r, cyc, loads);
         if (k == 4) bus.req = '0;
         chk($sformatf("t2_done_%0d", k),   32'(d), 32'(1 << t2_id[k]));
         chk($sformatf("t2_gnt_%0d", k),    32'(g), 32'(1 << t2_id[k]));
         chk($sformatf("t2_result_%0d", k), 32'(r), 32'(t2_p[t2_id[k]]));
      end
      tick(2);

      // 3: ptr=1; serve id1, then 0101 picks id2 before id0
      set_op(1, 3, 3);
      bus.req = 4'b0010;
      wait_done(d, g, r, cyc, loads);
      bus.req = 4'b0101;
      chk("t3_id1",   32'(d), 32'b0010);
      chk("t3_res1",  32'(r), 9);
      wait_done(d, g, r, cyc, loads);
      chk("t3_first", 32'(d), 32'b0100);
      chk("t3_res2",  32'(r), 1320);
      wait_done(d, g, r, cyc, loads);
      bus.req = '0;
      chk("t3_second", 32'(d), 32'b0001);
      chk("t3_res0",   32'(r), 35);
      // ptr=1; serve id3 so ptr wraps to 0, then 0011 must pick id0
      tick(1);
      bus.req = 4'b1000;
      wait_done(d, g, r, cyc, loads);
      bus.req = 4'b0011;
      chk("t3_id3",  32'(d), 32'b1000);
      wait_done(d, g, r, cyc, loads);
      bus.req = '0;
      chk("t3_wrap", 32'(d), 32'b0001);
      tick(2);

      // 4: reset during BUSY abandons the operation
      set_op(0, 5, 5);
      bus.req = 4'b0001;
      tick(4);
      chk("t4_busy_before", 32'(bus.busy), 1);
      rst     = 1'b0;
      bus.req = '0;
      tick(1);
      chk("t4_gnt",    32'(bus.gnt),    0);
      chk("t4_busy",   32'(bus.busy),   0);
      chk("t4_done",   32'(bus.done),   0);
      chk("t4_result", 32'(bus.result), 0);
      chk("t4_mul_a",  32'(mul_a),      0);
      chk("t4_load",   32'(mul_load),   0);
      chk("t4_mulrst", 32'(mul_rst),    1);
      rst = 1'b1;
      cnt_done = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (bus.done != '0) cnt_done++;
      end
      chk("t4_no_done", 32'(cnt_done), 0);
      set_op(2, 9, 9);
      bus.req = 4'b0100;
      wait_done(d, g, r, cyc, loads);
      bus.req = '0;
      chk("t4_new_done",   32'(d), 32'b0100);
      chk("t4_new_result", 32'(r), 81);
      tick(2);

      // 5: request dropped mid-operation, zero operand
      set_op(0, 0, 45);
      bus.req = 4'b0001;
      tick(4);
      bus.req = '0;
      wait_done(d, g, r, cyc, loads);
      chk("t5_done",   32'(d), 32'b0001);
      chk("t5_result", 32'(r), 0);
      tick(1);
      set_op(1, 2, 3);
      bus.req = 4'b0010;
      wait_done(d, g, r, cyc, loads);
      bus.req = '0;
      chk("t5_next_done",   32'(d), 32'b0010);
      chk("t5_next_result", 32'(r), 6);
      tick(2);

      // 6: operands changed after grant have no effect
      set_op(0, 7, 9);
      bus.req = 4'b0001;
      tick(3);
      set_op(0, 60, 60);
      tick(1);
      chk("t6_mul_a", 32'(mul_a), 7);
      chk("t6_mul_b", 32'(mul_b), 9);
      wait_done(d, g, r, cyc, loads);
      bus.req = '0;
      chk("t6_done",   32'(d), 32'b0001);
      chk("t6_result", 32'(r), 63);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
